// File: rtl/tilt_gesture_filter.sv
// Tilt-to-gesture filter: 4-sample moving average of X/Y, hysteretic left/right FSM, one-shot jump FSM.
// Mean registered at N+1 after a strobe, direction/jump at N+2; no backpressure, a strobe every cycle is accepted.
module tilt_gesture_filter #(
  parameter int LR_ON      = 100,
  parameter int LR_OFF     = 80,
  parameter int JUMP_ON    = 200,
  parameter int JUMP_OFF   = 150,
  parameter int JUMP_PULSE = 4,
  parameter int COOLDOWN   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_update,
  input  logic [15:0] data_x,
  input  logic [15:0] data_y,
  output logic [15:0] avg_x,
  output logic [15:0] avg_y,
  output logic        avg_valid,
  output logic        left,
  output logic        right,
  output logic        jump
);

  typedef enum logic [1:0] {DIR_CENTER, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {JMP_IDLE, JMP_FIRE, JMP_COOL} jmp_t;

  localparam logic [15:0] LP_PULSE_LAST = 16'(JUMP_PULSE - 1);
  localparam logic [15:0] LP_COOL_LAST  = 16'((COOLDOWN > 0) ? (COOLDOWN - 1) : 0);

  logic [15:0]        r_hx [4];
  logic [15:0]        r_hy [4];
  logic signed [17:0] r_sum_x;
  logic signed [17:0] r_sum_y;
  logic signed [17:0] w_sum_x_nxt;
  logic signed [17:0] w_sum_y_nxt;
  logic [2:0]         r_fill;

  dir_t               r_dir;
  dir_t               w_dir_nxt;
  jmp_t               r_jmp;
  jmp_t               w_jmp_nxt;
  logic [15:0]        r_cnt;
  logic [15:0]        w_cnt_nxt;
  logic               r_armed;
  logic               w_armed_nxt;

  logic signed [31:0] w_ax;
  logic signed [31:0] w_ay;

  // Sum of four 16-bit samples needs 18 bits, so the running sum cannot wrap.
  assign w_sum_x_nxt = r_sum_x + {{2{data_x[15]}}, data_x} - {{2{r_hx[3][15]}}, r_hx[3]};
  assign w_sum_y_nxt = r_sum_y + {{2{data_y[15]}}, data_y} - {{2{r_hy[3][15]}}, r_hy[3]};

  assign w_ax = {{16{avg_x[15]}}, avg_x};
  assign w_ay = {{16{avg_y[15]}}, avg_y};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_hx[i] <= '0;
        r_hy[i] <= '0;
      end
      r_sum_x   <= '0;
      r_sum_y   <= '0;
      r_fill    <= '0;
      avg_x     <= '0;
      avg_y     <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (data_update) begin
        r_hx[0] <= data_x;
        r_hy[0] <= data_y;
        for (int i = 1; i < 4; i++) begin
          r_hx[i] <= r_hx[i-1];
          r_hy[i] <= r_hy[i-1];
        end
        r_sum_x   <= w_sum_x_nxt;
        r_sum_y   <= w_sum_y_nxt;
        // Bits [17:2] are exactly sum >>> 2 (floor toward -inf).
        avg_x     <= w_sum_x_nxt[17:2];
        avg_y     <= w_sum_y_nxt[17:2];
        avg_valid <= (r_fill >= 3'd3);
        if (r_fill != 3'd4) begin
          r_fill <= r_fill + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dir   <= DIR_CENTER;
      r_jmp   <= JMP_IDLE;
      r_cnt   <= '0;
      r_armed <= 1'b1;
    end else begin
      r_dir   <= w_dir_nxt;
      r_jmp   <= w_jmp_nxt;
      r_cnt   <= w_cnt_nxt;
      r_armed <= w_armed_nxt;
    end
  end

  // A swing past the opposite threshold jumps straight across, skipping CENTER.
  always_comb begin
    w_dir_nxt = r_dir;
    if (avg_valid) begin
      case (r_dir)
        DIR_CENTER: begin
          if (w_ax > LR_ON) begin
            w_dir_nxt = DIR_LEFT;
          end else if (w_ax < -LR_ON) begin
            w_dir_nxt = DIR_RIGHT;
          end
        end
        DIR_LEFT: begin
          if (w_ax < -LR_ON) begin
            w_dir_nxt = DIR_RIGHT;
          end else if (w_ax <= LR_OFF) begin
            w_dir_nxt = DIR_CENTER;
          end
        end
        DIR_RIGHT: begin
          if (w_ax > LR_ON) begin
            w_dir_nxt = DIR_LEFT;
          end else if (w_ax >= -LR_OFF) begin
            w_dir_nxt = DIR_CENTER;
          end
        end
        default: w_dir_nxt = DIR_CENTER;
      endcase
    end
  end

  always_comb begin
    w_jmp_nxt   = r_jmp;
    w_cnt_nxt   = r_cnt;
    w_armed_nxt = r_armed;
    if (avg_valid && (w_ay <= JUMP_OFF)) begin
      w_armed_nxt = 1'b1;
    end
    case (r_jmp)
      JMP_IDLE: begin
        if (avg_valid && r_armed && (w_ay > JUMP_ON)) begin
          w_jmp_nxt   = JMP_FIRE;
          w_cnt_nxt   = '0;
          w_armed_nxt = 1'b0;
        end
      end
      JMP_FIRE: begin
        if (r_cnt == LP_PULSE_LAST) begin
          w_cnt_nxt = '0;
          if (COOLDOWN == 0) begin
            w_jmp_nxt = JMP_IDLE;
          end else begin
            w_jmp_nxt = JMP_COOL;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      JMP_COOL: begin
        if (r_cnt == LP_COOL_LAST) begin
          w_cnt_nxt = '0;
          w_jmp_nxt = JMP_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_jmp_nxt = JMP_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign left  = (r_dir == DIR_LEFT);
  assign right = (r_dir == DIR_RIGHT);
  assign jump  = (r_jmp == JMP_FIRE);

endmodule

// File: tb/tb_tilt_gesture_filter.sv
// Directed bench for tilt_gesture_filter with hand-computed expectations.
module tb_tilt_gesture_filter;

  logic        clk;
  logic        reset_n;
  logic        data_update;
  logic [15:0] data_x;
  logic [15:0] data_y;
  logic [15:0] avg_x;
  logic [15:0] avg_y;
  logic        avg_valid;
  logic        left;
  logic        right;
  logic        jump;

  int errors = 0;
  int checks = 0;

  tilt_gesture_filter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_update (data_update),
    .data_x      (data_x),
    .data_y      (data_y),
    .avg_x       (avg_x),
    .avg_y       (avg_y),
    .avg_valid   (avg_valid),
    .left        (left),
    .right       (right),
    .jump        (jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One-cycle strobe; returns at the negedge where the resulting mean is visible.
  task automatic send(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    data_update = 1'b1;
    data_x      = x;
    data_y      = y;
    @(negedge clk);
    data_update = 1'b0;
  endtask

  initial begin
    logic e;
    reset_n     = 1'b0;
    data_update = 1'b0;
    data_x      = '0;
    data_y      = '0;
    repeat (3) step();
    reset_n = 1'b1;
    chk16("rst_avg_x", avg_x, 16'd0);
    chk16("rst_avg_y", avg_y, 16'd0);
    chk1("rst_avg_valid", avg_valid, 1'b0);
    chk1("rst_left", left, 1'b0);
    chk1("rst_right", right, 1'b0);
    chk1("rst_jump", jump, 1'b0);

    // Fill and latency
    send(16'd120, 16'd0);
    chk1("fill_valid_1", avg_valid, 1'b0);
    send(16'd120, 16'd0);
    chk1("fill_valid_2", avg_valid, 1'b0);
    send(16'd120, 16'd0);
    chk1("fill_valid_3", avg_valid, 1'b0);
    chk1("fill_left_early", left, 1'b0);
    send(16'd120, 16'd0);
    chk1("fill_valid_4", avg_valid, 1'b1);
    chk16("fill_avg_x", avg_x, 16'd120);
    chk1("fill_left_n1", left, 1'b0);
    step();
    chk1("fill_left_n2", left, 1'b1);
    chk1("fill_right_n2", right, 1'b0);
    chk1("valid_single", avg_valid, 1'b0);

    // Hysteresis: means 112,105,97,90 keep LEFT; then 85 holds, 80 releases
    repeat (4) send(16'd90, 16'd0);
    step();
    chk16("hyst_avg_90", avg_x, 16'd90);
    chk1("hyst_left_90", left, 1'b1);
    send(16'd70, 16'd0);
    chk16("hyst_avg_85", avg_x, 16'd85);
    step();
    chk1("hyst_left_85", left, 1'b1);
    send(16'd70, 16'd0);
    chk16("hyst_avg_80", avg_x, 16'd80);
    step();
    chk1("hyst_left_80", left, 1'b0);
    chk1("hyst_right_80", right, 1'b0);
    send(16'd70, 16'd0);
    send(16'd70, 16'd0);

    // Rounding toward -inf
    send(16'hFFFF, 16'd0);
    repeat (3) send(16'd0, 16'd0);
    chk16("round_neg1", avg_x, 16'hFFFF);
    send(16'd1, 16'd0);
    repeat (3) send(16'd0, 16'd0);
    chk16("round_pos1", avg_x, 16'd0);
    step();
    chk1("round_center", left | right, 1'b0);

    // Jump one-shot with back-to-back strobes: y=250 x8, y=100 x4, then y=250.
    // Pulses expected at sampled cycles 5..8 and, after a 16-cycle cooldown, 26..29.
    step();
    for (int i = 0; i < 60; i++) begin
      e = ((i >= 5) && (i <= 8)) || ((i >= 26) && (i <= 29));
      chk1($sformatf("jump_cyc%0d", i), jump, e);
      data_update = 1'b1;
      data_x      = 16'd0;
      data_y      = ((i >= 8) && (i < 12)) ? 16'd100 : 16'd250;
      step();
    end
    data_update = 1'b0;
    chk16("jump_avg_y", avg_y, 16'd250);

    // Reset in the second FIRE cycle, with a coincident strobe that must be dropped
    repeat (4) send(16'd0, 16'd100);
    send(16'd0, 16'd250);
    send(16'd0, 16'd250);
    send(16'd0, 16'd250);
    chk16("pre_rst_avg_y", avg_y, 16'd212);
    step();
    chk1("fire_cycle1", jump, 1'b1);
    step();
    chk1("fire_cycle2", jump, 1'b1);
    reset_n     = 1'b0;
    data_update = 1'b1;
    data_y      = 16'd250;
    step();
    reset_n     = 1'b1;
    data_update = 1'b0;
    chk1("midrst_jump", jump, 1'b0);
    chk1("midrst_valid", avg_valid, 1'b0);
    chk16("midrst_avg_y", avg_y, 16'd0);
    send(16'd0, 16'd250);
    send(16'd0, 16'd250);
    send(16'd0, 16'd250);
    chk1("refill_valid_3", avg_valid, 1'b0);
    send(16'd0, 16'd250);
    chk1("refill_valid_4", avg_valid, 1'b1);
    chk16("refill_avg_y", avg_y, 16'd250);
    step();
    chk1("refill_armed_jump", jump, 1'b1);
    repeat (25) step();

    // Extremes, four strobes back-to-back
    for (int i = 0; i < 4; i++) begin
      data_update = 1'b1;
      data_x      = 16'h8000;
      data_y      = 16'd0;
      step();
    end
    data_update = 1'b0;
    chk1("ext_valid", avg_valid, 1'b1);
    chk16("ext_avg_x", avg_x, 16'h8000);
    step();
    chk1("ext_right", right, 1'b1);
    chk1("ext_left", left, 1'b0);
    chk1("ext_valid_drop", avg_valid, 1'b0);

    // RIGHT swings straight to LEFT: means -24546,-16324,-8102,120
    repeat (4) send(16'd120, 16'd0);
    chk16("swing_avg_x", avg_x, 16'd120);
    step();
    chk1("swing_left", left, 1'b1);
    chk1("swing_right", right, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tilt_gesture_filter.md
TILT_GESTURE_FILTER -- requirements
Module: tilt_gesture_filter

Interface
REQ-001 SHALL have parameter LR_ON, default 100: avg_x magnitude that enters LEFT or RIGHT.
REQ-002 SHALL have parameter LR_OFF, default 80: avg_x magnitude at or below which LEFT or RIGHT returns to CENTER.
REQ-003 SHALL have parameter JUMP_ON, default 200: avg_y level that fires a jump.
REQ-004 SHALL have parameter JUMP_OFF, default 150: avg_y level at or below which the jump re-arms.
REQ-005 SHALL have parameter JUMP_PULSE, default 4: jump high time in clk cycles, range 1..65535.
REQ-006 SHALL have parameter COOLDOWN, default 16: dead time in clk cycles after the pulse, range 0..65535.
REQ-007 SHALL have port clk  input  1: the single clock for all logic.
REQ-008 SHALL have port reset_n  input  1: synchronous, active-low reset.
REQ-009 SHALL have port data_update  input  1: single-cycle strobe marking a new sample.
REQ-010 SHALL have port data_x  input  16: signed two's-complement X sample.
REQ-011 SHALL have port data_y  input  16: signed two's-complement Y sample.
REQ-012 SHALL have port avg_x  output  16: signed 4-sample mean of X.
REQ-013 SHALL have port avg_y  output  16: signed 4-sample mean of Y.
REQ-014 SHALL have port avg_valid  output  1: single-cycle strobe marking a new mean.
REQ-015 SHALL have ports left, right, jump  output  1 each: movement commands.

Function
REQ-016 SHALL, on each data_update, shift data_x and data_y into separate 4-entry histories and update 18-bit signed running sums as sum + new - oldest.
REQ-017 SHALL form avg = sum >>> 2, an arithmetic shift that floors toward negative infinity; the sum never overflows.
REQ-018 SHALL register avg_x and avg_y and pulse avg_valid in cycle N+1 for a data_update in cycle N.
REQ-019 SHALL keep avg_valid low until the 4th sample after reset, using a fill counter that saturates at 4; the averaging data path still runs during fill.
REQ-020 SHALL accept back-to-back data_update strobes with no dropped samples.
REQ-021 SHALL implement a direction FSM with states CENTER, LEFT and RIGHT, evaluated only in cycles where avg_valid=1; its outputs update the following cycle, N+2 from data_update.
REQ-022 SHALL take these direction transitions:
- CENTER->LEFT if avg_x > LR_ON.
- CENTER->RIGHT if avg_x < -LR_ON.
- LEFT->RIGHT if avg_x < -LR_ON, overriding the LEFT->CENTER rule.
- LEFT->CENTER if avg_x <= LR_OFF.
- RIGHT and RIGHT->LEFT are the mirror of the LEFT rules.
- Otherwise the state holds.
REQ-023 SHALL drive left=1 only in state LEFT and right=1 only in state RIGHT, never both at once.
REQ-024 SHALL implement a jump FSM with states IDLE, FIRE and COOL, plus an armed flag.
REQ-025 SHALL go IDLE->FIRE when avg_valid=1, armed=1 and avg_y > JUMP_ON; entering FIRE clears armed.
REQ-026 SHALL set armed in any state on a cycle where avg_valid=1 and avg_y <= JUMP_OFF.
REQ-027 SHALL hold jump=1 for exactly JUMP_PULSE cycles in FIRE, then spend COOLDOWN cycles in COOL (skipped when COOLDOWN=0), then return to IDLE.
REQ-028 SHALL ignore avg_y above JUMP_ON while in FIRE or COOL; averaging and direction logic keep running throughout.

Reset
REQ-029 SHALL, when reset_n=0 at a clk edge, clear histories, sums, fill count, avg_x, avg_y, avg_valid, left, right and jump to 0, with direction=CENTER, jump FSM=IDLE and armed=1.
REQ-030 SHALL take effect from the next edge even mid-FIRE or mid-fill; a data_update coincident with reset is discarded.

Verification
REQ-031 SHALL cover fill and latency: four strobes with x=120 -> avg_valid low for strobes 1-3; avg_x=120 and avg_valid=1 at N+1 after strobe 4; left=1 at N+2.
REQ-032 SHALL cover hysteresis: from LEFT, feed four x=90 -> left stays 1; then four x=70 -> left=0 once avg_x <= 80.
REQ-033 SHALL cover rounding: samples x=-1,0,0,0 -> avg_x=-1 (0xFFFF); samples x=1,0,0,0 -> avg_x=0.
REQ-034 SHALL cover the jump one-shot: sustained y=250 -> jump high exactly 4 cycles followed by 16 dead cycles, with no second pulse; after four y=100 then four y=250 -> a second 4-cycle pulse.
REQ-035 SHALL cover reset mid-pulse: reset_n=0 for 1 cycle in the 2nd FIRE cycle -> jump=0 next cycle, avg_valid stays low until 4 new strobes, and armed=1.
REQ-036 SHALL cover extremes: four samples x=-32768 -> avg_x=-32768 and right=1 with no overflow.
